// File: rtl/vga_pkg.sv
// XGA (1024x768 @ 60 Hz) default timing constants and count widths shared by the
// VGA timing generator and its axis counters.
package vga_pkg;

   localparam int unsigned CNT_W   = 11;
   localparam int unsigned FRAME_W = 16;

   localparam int unsigned XGA_H_ACTIVE = 1024;
   localparam int unsigned XGA_H_FP     = 24;
   localparam int unsigned XGA_H_SYNC   = 136;
   localparam int unsigned XGA_H_BP     = 160;
   localparam int unsigned XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

   localparam int unsigned XGA_V_ACTIVE = 768;
   localparam int unsigned XGA_V_FP     = 3;
   localparam int unsigned XGA_V_SYNC   = 6;
   localparam int unsigned XGA_V_BP     = 29;
   localparam int unsigned XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus registered blank/sync flags,
// decoded from the next count value so the flags never lag the count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = XGA_H_ACTIVE,
   parameter int unsigned FP     = XGA_H_FP,
   parameter int unsigned SYNC   = XGA_H_SYNC,
   parameter int unsigned BP     = XGA_H_BP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             blank,
   output logic             sync,
   output logic             wrap_c
);

   localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
   localparam int unsigned SYNC_START = ACTIVE + FP;
   localparam int unsigned SYNC_END   = SYNC_START + SYNC;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blank_q, blank_d;
   logic             sync_q, sync_d;

   always_comb begin
      wrap_c  = en && (cnt_q == CNT_W'(TOTAL - 1));
      cnt_d   = cnt_q;
      if (wrap_c) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      blank_d = (cnt_d >= CNT_W'(ACTIVE));
      sync_d  = (cnt_d >= CNT_W'(SYNC_START)) && (cnt_d < CNT_W'(SYNC_END));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         blank_q <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         blank_q <= blank_d;
         sync_q  <= sync_d;
      end
   end

   assign cnt   = cnt_q;
   assign blank = blank_q;
   assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, blanking, sync, start-of-frame.
// Define VGA_FRAME_COUNT_EN to build the completed-frame counter; otherwise frame_cnt is 0.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = XGA_H_ACTIVE,
   parameter int unsigned H_FP     = XGA_H_FP,
   parameter int unsigned H_SYNC   = XGA_H_SYNC,
   parameter int unsigned H_BP     = XGA_H_BP,
   parameter int unsigned V_ACTIVE = XGA_V_ACTIVE,
   parameter int unsigned V_FP     = XGA_V_FP,
   parameter int unsigned V_SYNC   = XGA_V_SYNC,
   parameter int unsigned V_BP     = XGA_V_BP
) (
   input  logic               clk,
   input  logic               rst,
   output logic [CNT_W-1:0]   hcount,
   output logic [CNT_W-1:0]   vcount,
   output logic               hblnk,
   output logic               vblnk,
   output logic               hs,
   output logic               vs,
   output logic               sof,
   output logic [FRAME_W-1:0] frame_cnt
);

   logic h_wrap_c;
   logic v_wrap_c;
   logic sof_q, sof_d;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk    (clk),
      .rst    (rst),
      .en     (1'b1),
      .cnt    (hcount),
      .blank  (hblnk),
      .sync   (hs),
      .wrap_c (h_wrap_c)
   );

   // Vertical axis advances only on the horizontal wrap cycle.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk    (clk),
      .rst    (rst),
      .en     (h_wrap_c),
      .cnt    (vcount),
      .blank  (vblnk),
      .sync   (vs),
      .wrap_c (v_wrap_c)
   );

   // Both axes wrapping means the next pixel is (0,0); reset also lands on (0,0).
   always_comb begin
      sof_d = h_wrap_c && v_wrap_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sof_q <= 1'b1;
      end else begin
         sof_q <= sof_d;
      end
   end

   assign sof = sof_q;

`ifdef VGA_FRAME_COUNT_EN
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (sof_d) begin
         frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a shrunk-timing instance for whole frames and
// resets, plus a default XGA instance for horizontal line timing.
module tb_vga_timing_gen;

   localparam int S_HA = 8;
   localparam int S_HF = 2;
   localparam int S_HS = 3;
   localparam int S_HB = 3;
   localparam int S_HT = 16;
   localparam int S_VA = 4;
   localparam int S_VF = 1;
   localparam int S_VS = 2;
   localparam int S_VB = 1;
   localparam int S_VT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [10:0] s_hcount, s_vcount, d_hcount, d_vcount;
   logic        s_hblnk, s_vblnk, s_hs, s_vs, s_sof;
   logic        d_hblnk, d_vblnk, d_hs, d_vs, d_sof;
   logic [15:0] s_frame_cnt, d_frame_cnt;

   int checks = 0;
   int errors = 0;
   int eh = 0, ev = 0, efc = 0;
   int dh = 0, dv = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
      .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
   ) u_small (
      .clk       (clk),
      .rst       (rst),
      .hcount    (s_hcount),
      .vcount    (s_vcount),
      .hblnk     (s_hblnk),
      .vblnk     (s_vblnk),
      .hs        (s_hs),
      .vs        (s_vs),
      .sof       (s_sof),
      .frame_cnt (s_frame_cnt)
   );

   vga_timing_gen u_xga (
      .clk       (clk),
      .rst       (rst),
      .hcount    (d_hcount),
      .vcount    (d_vcount),
      .hblnk     (d_hblnk),
      .vblnk     (d_vblnk),
      .hs        (d_hs),
      .vs        (d_vs),
      .sof       (d_sof),
      .frame_cnt (d_frame_cnt)
   );

   function automatic int exp_fc();
`ifdef VGA_FRAME_COUNT_EN
      return efc % 65536;
`else
      return 0;
`endif
   endfunction

   // Advance one clock and update the reference positions of both instances.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         eh = 0; ev = 0; efc = 0; dh = 0; dv = 0;
      end else begin
         if (eh == S_HT - 1) begin
            eh = 0;
            if (ev == S_VT - 1) begin ev = 0; efc++; end
            else ev++;
         end else eh++;
         if (dh == 1343) begin
            dh = 0;
            dv = (dv == 805) ? 0 : dv + 1;
         end else dh++;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++; if (s_hcount !== 11'd0 || s_vcount !== 11'd0) begin errors++;
         $display("FAIL reset_counts got h=%0d v=%0d exp 0 0", s_hcount, s_vcount); end
      checks++; if ({s_hblnk, s_vblnk, s_hs, s_vs} !== 4'b0000) begin errors++;
         $display("FAIL reset_flags got %b exp 0000", {s_hblnk, s_vblnk, s_hs, s_vs}); end
      checks++; if (s_frame_cnt !== 16'd0) begin errors++;
         $display("FAIL reset_frame_cnt got %0d exp 0", s_frame_cnt); end
      checks++; if (d_hcount !== 11'd0 || d_hs !== 1'b0 || d_hblnk !== 1'b0) begin errors++;
         $display("FAIL reset_xga got h=%0d hs=%b hb=%b exp 0 0 0", d_hcount, d_hs, d_hblnk); end
      rst = 1'b0;
      checks++; if (s_sof !== 1'b1 || s_hcount !== 11'd0) begin errors++;
         $display("FAIL release_first got sof=%b h=%0d exp 1 0", s_sof, s_hcount); end
      step();
      checks++; if (s_hcount !== 11'd1 || s_sof !== 1'b0 || s_vcount !== 11'd0) begin errors++;
         $display("FAIL release_next got h=%0d v=%0d sof=%b exp 1 0 0", s_hcount, s_vcount, s_sof); end
   endtask

   // Every-cycle comparison of the small instance over more than three frames.
   task automatic test_small_frames();
      for (int i = 0; i < 3 * S_HT * S_VT + 20; i++) begin
         step();
         checks++; if (s_hcount !== 11'(eh) || s_vcount !== 11'(ev)) begin errors++;
            $display("FAIL frame_counts got %0d,%0d exp %0d,%0d", s_hcount, s_vcount, eh, ev); end
         checks++; if (s_hblnk !== (eh >= S_HA) || s_vblnk !== (ev >= S_VA)) begin errors++;
            $display("FAIL frame_blank at %0d,%0d got %b%b", eh, ev, s_hblnk, s_vblnk); end
         checks++; if (s_hs !== (eh >= 10 && eh <= 12) || s_vs !== (ev >= 5 && ev <= 6)) begin
            errors++; $display("FAIL frame_sync at %0d,%0d got hs=%b vs=%b", eh, ev, s_hs, s_vs); end
         checks++; if (s_sof !== (eh == 0 && ev == 0)) begin errors++;
            $display("FAIL frame_sof at %0d,%0d got %b", eh, ev, s_sof); end
         checks++; if (s_frame_cnt !== 16'(exp_fc())) begin errors++;
            $display("FAIL frame_cnt got %0d exp %0d", s_frame_cnt, exp_fc()); end
      end
   endtask

   task automatic test_frame_wrap();
      bit found = 1'b0;
      int fc_before;
      for (int i = 0; i < 2 * S_HT * S_VT && !found; i++) begin
         if (eh == S_HT - 1 && ev == S_VT - 1) found = 1'b1;
         else step();
      end
      checks++; if (!found) begin errors++;
         $display("FAIL wrap_reach got %0d,%0d exp 15,7", eh, ev); end
      checks++; if (s_hcount !== 11'd15 || s_vcount !== 11'd7 || s_vblnk !== 1'b1) begin errors++;
         $display("FAIL wrap_last got %0d,%0d vb=%b exp 15,7 1", s_hcount, s_vcount, s_vblnk); end
      fc_before = exp_fc();
      step();
      checks++; if (s_hcount !== 11'd0 || s_vcount !== 11'd0 || s_sof !== 1'b1) begin errors++;
         $display("FAIL wrap_first got %0d,%0d sof=%b exp 0,0 1", s_hcount, s_vcount, s_sof); end
`ifdef VGA_FRAME_COUNT_EN
      checks++; if (s_frame_cnt !== 16'(fc_before + 1)) begin errors++;
         $display("FAIL wrap_frame_cnt got %0d exp %0d", s_frame_cnt, fc_before + 1); end
`else
      checks++; if (s_frame_cnt !== 16'd0) begin errors++;
         $display("FAIL wrap_frame_cnt got %0d exp 0 (fc_before %0d)", s_frame_cnt, fc_before); end
`endif
   endtask

   // Reset pulse inside both sync windows of the small instance.
   task automatic test_mid_reset();
      bit found = 1'b0;
      for (int i = 0; i < 2 * S_HT * S_VT && !found; i++) begin
         if (eh == 11 && ev == 5) found = 1'b1;
         else step();
      end
      checks++; if (!found || s_hs !== 1'b1 || s_vs !== 1'b1) begin errors++;
         $display("FAIL midrst_setup got hs=%b vs=%b found=%b exp 1 1 1", s_hs, s_vs, found); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (s_hcount !== 11'd0 || s_vcount !== 11'd0) begin errors++;
         $display("FAIL midrst_counts got %0d,%0d exp 0,0", s_hcount, s_vcount); end
      checks++; if ({s_hblnk, s_vblnk, s_hs, s_vs, s_sof} !== 5'b00001) begin errors++;
         $display("FAIL midrst_flags got %b exp 00001", {s_hblnk, s_vblnk, s_hs, s_vs, s_sof}); end
      checks++; if (s_frame_cnt !== 16'd0) begin errors++;
         $display("FAIL midrst_frame_cnt got %0d exp 0", s_frame_cnt); end
      repeat (S_HT + 2) step();
      checks++; if (s_hcount !== 11'd2 || s_vcount !== 11'd1 || s_frame_cnt !== 16'd0) begin
         errors++; $display("FAIL midrst_restart got %0d,%0d fc=%0d exp 2,1 fc=0",
                            s_hcount, s_vcount, s_frame_cnt); end
   endtask

   // XGA line timing: hblnk from 1024, hs 136 clocks from 1048, period 1344.
   task automatic test_xga_line();
      int  cyc = 0, last_rise = -1, high_len = 0, rises = 0;
      logic prev_hs = d_hs;
      for (int i = 0; i < 3000; i++) begin
         step();
         cyc++;
         checks++; if (d_hcount !== 11'(dh) || d_vcount !== 11'(dv)) begin errors++;
            $display("FAIL xga_counts got %0d,%0d exp %0d,%0d", d_hcount, d_vcount, dh, dv); end
         checks++; if (d_hblnk !== (dh >= 1024) || d_vblnk !== 1'b0 || d_vs !== 1'b0) begin
            errors++; $display("FAIL xga_blank at %0d got hb=%b vb=%b vs=%b", dh, d_hblnk,
                               d_vblnk, d_vs); end
         checks++; if (d_hs !== (dh >= 1048 && dh <= 1183)) begin errors++;
            $display("FAIL xga_hs at %0d got %b", dh, d_hs); end
         if (d_hs === 1'b1 && prev_hs === 1'b0) begin
            rises++;
            checks++; if (d_hcount !== 11'd1048) begin errors++;
               $display("FAIL xga_hs_start got %0d exp 1048", d_hcount); end
            if (last_rise >= 0) begin
               checks++; if (cyc - last_rise !== 1344) begin errors++;
                  $display("FAIL xga_hs_period got %0d exp 1344", cyc - last_rise); end
            end
            last_rise = cyc;
            high_len = 0;
         end
         if (d_hs === 1'b1) high_len++;
         if (d_hs === 1'b0 && prev_hs === 1'b1) begin
            checks++; if (high_len !== 136) begin errors++;
               $display("FAIL xga_hs_width got %0d exp 136", high_len); end
         end
         prev_hs = d_hs;
      end
      checks++; if (rises < 2) begin errors++;
         $display("FAIL xga_hs_rises got %0d exp >=2", rises); end
   endtask

   initial begin
      #1;
      test_reset();
      test_small_frames();
      test_frame_wrap();
      test_mid_reset();
      test_xga_line();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
